// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - load/store unit: one outstanding data-bus access per ALU2 instruction
// Drives request, byte lanes and store data; returns aligned, extended load data.
module rv_lsu #(
  parameter int ACK_TIMEOUT = 0,
  parameter int CNT_W       = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_data_req,
  output logic        o_data_write,
  output logic [31:0] o_data_addr,
  output logic [3:0]  o_data_sel,
  output logic [31:0] o_data_wdata,
  input  logic [31:0] i_data_rdata,
  input  logic        i_data_ack,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_fault,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  localparam bit             TO_EN   = (ACK_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               write_q, write_d;
  logic               load_q, load_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         off_q, off_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               fault_q, fault_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        access, legal, aligned, start, timeout_hit;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new, shifted, load_ext;

  always_comb begin
    access = i_valid & (i_mem_rd | i_mem_wr) & ~i_flush;
    legal  = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = i_mem_rd;
      default:                legal = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b01:   aligned = ~i_addr[0];
      2'b10:   aligned = (i_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    start = access & legal & aligned;

    case (i_funct3[1:0])
      2'b00: begin
        sel_new   = 4'b0001 << i_addr[1:0];
        wdata_new = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        sel_new   = 4'b0011 << {i_addr[1], 1'b0};
        wdata_new = {2{i_wdata[15:0]}};
      end
      default: begin
        sel_new   = 4'b1111;
        wdata_new = i_wdata;
      end
    endcase

    shifted = i_data_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase

    // An ack arriving on the last counted cycle completes normally.
    timeout_hit = TO_EN && (cnt_q == TO_LAST) && !i_data_ack;
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    write_d   = write_q;
    load_d    = load_q;
    addr_d    = addr_q;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    f3_d      = f3_q;
    off_d     = off_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    fault_d   = 1'b0;
    bus_err_d = 1'b0;
    cnt_d     = cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = REQ;
          req_d   = 1'b1;
          write_d = i_mem_wr;
          load_d  = i_mem_rd;
          addr_d  = {i_addr[31:2], 2'b00};
          sel_d   = sel_new;
          wdata_d = wdata_new;
          f3_d    = i_funct3;
          off_d   = i_addr[1:0];
        end else if (access) begin
          fault_d = 1'b1;
        end
      end
      REQ: begin
        if (i_data_ack) begin
          req_d   = 1'b0;
          state_d = i_flush ? IDLE : DONE;
          if (load_q && !i_flush) begin
            rdata_d  = load_ext;
            rvalid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          req_d     = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else if (i_flush) begin
          // The bus transaction cannot be recalled; finish it silently.
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (i_data_ack || timeout_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      write_q   <= 1'b0;
      load_q    <= 1'b0;
      addr_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      fault_q   <= 1'b0;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      write_q   <= write_d;
      load_q    <= load_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      f3_q      <= f3_d;
      off_q     <= off_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      fault_q   <= fault_d;
      bus_err_q <= bus_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_data_req    = req_q;
  assign o_data_write  = write_q;
  assign o_data_addr   = addr_q;
  assign o_data_sel    = sel_q;
  assign o_data_wdata  = wdata_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q & ~i_flush;
  assign o_fault       = fault_q;
  assign o_bus_err     = bus_err_q;
  assign o_ready       = !((state_q == REQ) || (state_q == DRAIN) || ((state_q == IDLE) && start));

endmodule

// File: tb/tb_rv_lsu.sv
// tb/tb_rv_lsu.sv - directed vector bench for rv_lsu
module tb_rv_lsu;

  logic        clk, rst_n, i_flush, i_valid, i_mem_rd, i_mem_wr;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_data_rdata;
  logic        i_data_ack;
  logic        o_data_req, o_data_write, o_ready, o_rdata_valid, o_fault, o_bus_err;
  logic [31:0] o_data_addr, o_data_wdata, o_rdata;
  logic [3:0]  o_data_sel;

  int checks = 0;
  int errors = 0;

  rv_lsu #(.ACK_TIMEOUT(4), .CNT_W(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_funct3(i_funct3), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_data_req(o_data_req), .o_data_write(o_data_write),
    .o_data_addr(o_data_addr), .o_data_sel(o_data_sel), .o_data_wdata(o_data_wdata),
    .i_data_rdata(i_data_rdata), .i_data_ack(i_data_ack), .o_ready(o_ready),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_fault(o_fault), .o_bus_err(o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  sel;
    logic [31:0] bwdata;
    logic [31:0] res;
    logic        fault;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr;
    i_funct3 = f3; i_addr = addr; i_wdata = wdata;
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int low;
    @(negedge clk);
    drive(v.rd, v.wr, v.f3, v.addr, v.wdata);
    #1;
    if (v.fault) begin
      chk("fault_ready", o_ready, 1);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("fault_pulse", o_fault, 1);
      chk("fault_noreq", o_data_req, 0);
      chk("fault_ready2", o_ready, 1);
      @(negedge clk);
      #1;
      chk("fault_clear", o_fault, 0);
      chk("fault_noreq2", o_data_req, 0);
    end else begin
      low = (o_ready == 1'b0) ? 1 : 0;
      for (int k = 1; k <= v.dly; k++) begin
        @(negedge clk);
        #1;
        if (!o_ready) low++;
        chk("req_high", o_data_req, 1);
        chk("sel", o_data_sel, v.sel);
        chk("addr", o_data_addr, v.addr & 32'hFFFF_FFFC);
        chk("bus_wdata", o_data_wdata, v.bwdata);
        chk("write", o_data_write, v.wr);
        if (k == v.dly) begin
          i_data_ack = 1'b1;
          i_data_rdata = v.rdata;
        end
      end
      @(negedge clk);
      i_data_ack = 1'b0;
      i_data_rdata = 32'h0;
      #1;
      chk("done_req", o_data_req, 0);
      chk("done_ready", o_ready, 1);
      chk("done_rvalid", o_rdata_valid, v.rd);
      if (v.rd) chk("load_result", o_rdata, v.res);
      chk("ready_low_cycles", low, v.dly + 1);
      idle_inputs();
      @(negedge clk);
      #1;
      chk("idle_rvalid", o_rdata_valid, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80123456, 1, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80123456, 2, 4'b1000, 32'h0, 32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 1, 4'b1100, 32'h0, 32'h0000BEEF, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'hBEEF1234, 2, 4'b1100, 32'h0, 32'hFFFFBEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h12348001, 1, 4'b0011, 32'h0, 32'hFFFF8001, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 4'b0010, 32'h0, 32'h0000007F, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 2, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 32'h0, 3, 4'b1111, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 3'b100, 32'h104, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1};

    rst_n = 1'b0; i_flush = 1'b0; i_data_ack = 1'b0; i_data_rdata = 32'h0;
    i_funct3 = 3'b0; i_addr = 32'h0; i_wdata = 32'h0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", o_data_req, 0);
    chk("rst_write", o_data_write, 0);
    chk("rst_addr", o_data_addr, 0);
    chk("rst_sel", o_data_sel, 0);
    chk("rst_wdata", o_data_wdata, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_rvalid", o_rdata_valid, 0);
    chk("rst_fault", o_fault, 0);
    chk("rst_buserr", o_bus_err, 0);
    chk("rst_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Illegal funct3 on a load
    run_vec('{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1'b1});

    // Flush one cycle into a load: request held until ack, no result
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    i_flush = 1'b1;
    #1;
    chk("fl_req0", o_data_req, 1);
    @(negedge clk);
    i_flush = 1'b0;
    idle_inputs();
    #1;
    chk("fl_req1", o_data_req, 1);
    chk("fl_ready1", o_ready, 0);
    @(negedge clk);
    #1;
    chk("fl_req2", o_data_req, 1);
    chk("fl_ready2", o_ready, 0);
    i_data_ack = 1'b1;
    i_data_rdata = 32'h55555555;
    @(negedge clk);
    i_data_ack = 1'b0;
    #1;
    chk("fl_req_drop", o_data_req, 0);
    chk("fl_ready_back", o_ready, 1);
    chk("fl_no_rvalid", o_rdata_valid, 0);
    @(negedge clk);
    #1;
    chk("fl_no_rvalid2", o_rdata_valid, 0);
    chk("fl_no_buserr", o_bus_err, 0);

    // Timeout: request held four cycles, then bus error
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk("to_req_held", o_data_req, 1);
      chk("to_no_err", o_bus_err, 0);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("to_req_drop", o_data_req, 0);
    chk("to_buserr", o_bus_err, 1);
    chk("to_ready", o_ready, 1);
    chk("to_no_rvalid", o_rdata_valid, 0);
    @(negedge clk);
    #1;
    chk("to_buserr_clear", o_bus_err, 0);

    // Ack on the timeout cycle completes the load
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        i_data_ack = 1'b1;
        i_data_rdata = 32'h11223344;
      end
    end
    @(negedge clk);
    i_data_ack = 1'b0;
    #1;
    chk("tie_rvalid", o_rdata_valid, 1);
    chk("tie_rdata", o_rdata, 32'h11223344);
    chk("tie_no_err", o_bus_err, 0);
    idle_inputs();
    @(negedge clk);

    // Flush during DONE suppresses the result pulse
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    @(negedge clk);
    i_data_ack = 1'b1;
    i_data_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    i_data_ack = 1'b0;
    i_flush = 1'b1;
    #1;
    chk("done_flush_rvalid", o_rdata_valid, 0);
    @(negedge clk);
    i_flush = 1'b0;
    idle_inputs();
    #1;
    chk("done_flush_rvalid2", o_rdata_valid, 0);

    // Async reset in the middle of a request
    @(negedge clk);
    drive(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    @(negedge clk);
    #1;
    chk("ar_req_before", o_data_req, 1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("ar_req_drop", o_data_req, 0);
    chk("ar_ready", o_ready, 1);
    chk("ar_sel", o_data_sel, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_stay_idle", o_data_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
